nbcac_di_decoder_seq: RTL and testbench
=======================================

Name: nbcac_di_decoder_seq

Overview:
- Parametrised, multi-cycle successor to the combinational NBCAC double-interface decoder core. It maps an N-bit NBCAC codeword d[N:1] to a VW-bit value.
- Weights follow the doubled-Fibonacci sequence, generated on the fly instead of stored as constants.
- Decodes BPC codeword bits per cycle behind valid/ready handshakes on input and output.
- Sits between the bus receiver register and the data sink, where one codeword per several cycles suffices and area is the priority.

Parameters:
- N, 17, codeword width (bits d[N:1]); N >= 3.
- VW, 12, decoded value width.
- BPC, 1, codeword bits consumed per RUN cycle; legal values 1/2/4/8; (N-1) % BPC == 0 (elaboration error otherwise).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  codeword on d is valid.
- in_ready  output  1  block can accept a codeword.
- d  input  N  codeword, bit index N..1.
- out_valid  output  1  v/ovf hold a valid result.
- out_ready  input  1  sink accepts the result.
- v  output  VW  decoded value (sum mod 2^VW).
- ovf  output  1  true sum >= 2^VW (codeword out of range for VW).
- busy  output  1  state != IDLE.

Behaviour:
- Interface: one clock clk; reset rst is asynchronous, active-high.
- Weights:
  - w(1)=1.
  - w(N)=2, w(N-1)=2, w(k)=w(k+1)+w(k+2) for k = N-2 down to 2.
  - For N=17 this gives 2,2,4,6,10,16,26,42,68,110,178,288,466,754,1220,1974.
- Registers:
  - sh (N-1 bit shift register, holds d[N:2] MSB first).
  - acc (VW+1 bits).
  - cur, prev (VW+1 bits, saturating at 2^VW).
  - cnt (counts RUN cycles).
  - sticky ovf.
- FSM states IDLE, RUN, DONE. Reset forces IDLE, in_ready=0 during reset then 1, out_valid=0, v=0, ovf=0, busy=0, all datapath registers 0.
- IDLE:
  - in_ready=1.
  - On in_valid: sh<=d[N:2], acc<=d[1], cur<=2, prev<=0, cnt<=0, ovf<=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, BPC unrolled steps, each step doing: bit = sh MSB; if bit, acc += cur; shift sh left; (cur,prev) <= (cur+prev, cur).
  - cnt += 1.
  - ovf sets if any acc update carries into bit VW, or adds a weight saturated at >= 2^VW. acc keeps the low VW bits after a carry.
  - When cnt reaches (N-1)/BPC - 1, the step completes and the FSM goes to DONE.
- DONE:
  - out_valid=1; v=acc[VW-1:0] and ovf stay stable.
  - On out_ready: go to IDLE and deassert out_valid next cycle.
  - out_ready in other states is ignored.
- Latency: handshake accepted at edge t gives out_valid high from edge t+(N-1)/BPC+1. Throughput is one codeword per (N-1)/BPC+2 cycles when out_ready is held 1.
- in_valid while in_ready=0 is ignored; the source must hold it. d is sampled only on the accepting edge.
- Back-pressure: DONE is held indefinitely while out_ready=0; no new codeword is accepted.
- Reset asserted mid-RUN or mid-DONE aborts immediately; the result is discarded and all outputs return to reset values.
- No codeword legality check; only the range check is reported via ovf.

Test Plan:
- N=17, BPC=1, d=17'h00000, out_ready=1 -> out_valid at accept+17, v=0, ovf=0.
- d with only d[1]=1 -> v=1. Only d[2]=1 -> v=1974. Only d[17]=1 -> v=2. All ovf=0.
- d[3]=d[2]=d[1]=1 (d=17'h00007) -> v=3195, ovf=0; repeat with BPC=2 and BPC=4 -> same v, latency 9 and 5.
- d=17'h1FFFF -> true sum 5167, v=1071, ovf=1.
- Hold out_ready=0 for 10 cycles in DONE while in_valid=1 with a new d -> v stable, in_ready=0, second codeword accepted only after out_ready pulse.
- Assert rst at RUN cycle 5, then release and decode d=17'h00002 -> outputs zero during reset, no stale out_valid, result v=1974.

Source files
------------

// File: rtl/nbcac_di_decoder_seq_if.sv
// rtl/nbcac_di_decoder_seq_if.sv - codeword in / decoded value out handshake bundle
interface nbcac_di_decoder_seq_if #(
  parameter int N  = 17,
  parameter int VW = 12
) ();
  logic          in_valid;
  logic          in_ready;
  logic [N:1]    d;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] v;
  logic          ovf;
  logic          busy;

  modport master (
    output in_valid, d, out_ready,
    input  in_ready, out_valid, v, ovf, busy
  );

  modport slave (
    input  in_valid, d, out_ready,
    output in_ready, out_valid, v, ovf, busy
  );
endinterface

// File: rtl/nbcac_di_decoder_seq.sv
// rtl/nbcac_di_decoder_seq.sv - bit-serial NBCAC codeword decoder
// Doubled-Fibonacci weights are generated on the fly, BPC codeword bits per RUN cycle.
module nbcac_di_decoder_seq #(
  parameter int N   = 17,
  parameter int VW  = 12,
  parameter int BPC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  nbcac_di_decoder_seq_if.slave bus
);

  localparam int STEPS = (N - 1) / BPC;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
  localparam logic [VW+1:0] SAT  = {2'b01, {VW{1'b0}}};

  generate
    if (N < 3 || !(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8) || ((N - 1) % BPC) != 0) begin : g_bad_param
      $error("nbcac_di_decoder_seq: illegal N/BPC combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_n;
  logic [N-2:0]  sh, sh_n;
  logic [VW:0]   acc, acc_n;
  logic [VW:0]   cur, cur_n;
  logic [VW:0]   prev, prev_n;
  logic [VW:0]   sum;
  logic [VW+1:0] nxt;
  logic [CW-1:0] cnt;
  logic          ovf_q, ovf_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_n = RUN;
      RUN:     if (cnt == LAST)   state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // BPC unrolled steps; a carry out of the low VW bits (including any add
  // of a saturated weight) sets the sticky range flag.
  always_comb begin
    sh_n   = sh;
    acc_n  = acc;
    cur_n  = cur;
    prev_n = prev;
    ovf_n  = ovf_q;
    sum    = '0;
    nxt    = '0;
    for (int i = 0; i < BPC; i++) begin
      if (sh_n[N-2]) begin
        sum   = acc_n + cur_n;
        ovf_n = ovf_n | sum[VW];
        acc_n = {1'b0, sum[VW-1:0]};
      end
      sh_n   = {sh_n[N-3:0], 1'b0};
      nxt    = {1'b0, cur_n} + {1'b0, prev_n};
      prev_n = cur_n;
      cur_n  = (nxt >= SAT) ? SAT[VW:0] : nxt[VW:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh    <= '0;
      acc   <= '0;
      cur   <= '0;
      prev  <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sh    <= bus.d[N:2];
          acc   <= {{VW{1'b0}}, bus.d[1]};
          cur   <= (VW+1)'(2);
          prev  <= '0;
          cnt   <= '0;
          ovf_q <= 1'b0;
        end
        RUN: begin
          sh    <= sh_n;
          acc   <= acc_n;
          cur   <= cur_n;
          prev  <= prev_n;
          cnt   <= cnt + 1'b1;
          ovf_q <= ovf_n;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.v         = (state == DONE) ? acc[VW-1:0] : '0;
  assign bus.ovf       = (state == DONE) ? ovf_q : 1'b0;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_nbcac_di_decoder_seq.sv
// tb/tb_nbcac_di_decoder_seq.sv - self-checking bench for nbcac_di_decoder_seq
// Three decoders (BPC 1/2/4) share one stimulus stream; BPC=1 is the primary target.
module tb_nbcac_di_decoder_seq;
  localparam int N  = 17;
  localparam int VW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [N:1]    d;
  logic          out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  nbcac_di_decoder_seq_if #(.N(N), .VW(VW)) b1 ();
  nbcac_di_decoder_seq_if #(.N(N), .VW(VW)) b2 ();
  nbcac_di_decoder_seq_if #(.N(N), .VW(VW)) b4 ();

  assign b1.in_valid = in_valid;
  assign b1.d = d;
  assign b1.out_ready = out_ready;
  assign b2.in_valid = in_valid;
  assign b2.d = d;
  assign b2.out_ready = out_ready;
  assign b4.in_valid = in_valid;
  assign b4.d = d;
  assign b4.out_ready = out_ready;

  nbcac_di_decoder_seq #(.N(N), .VW(VW), .BPC(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
  nbcac_di_decoder_seq #(.N(N), .VW(VW), .BPC(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));
  nbcac_di_decoder_seq #(.N(N), .VW(VW), .BPC(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));

  always #5 clk = ~clk;

  typedef struct {
    logic [N:1]    d;
    logic [VW-1:0] v;
    logic          ovf;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: weights straight from their recurrence, plain integer sum.
  function automatic void model(input logic [N:1] dv, output logic [VW-1:0] mv, output logic mo);
    int w [N+1];
    int s;
    w[1] = 1;
    w[N] = 2;
    w[N-1] = 2;
    for (int k = N - 2; k >= 2; k--) w[k] = w[k+1] + w[k+2];
    s = 0;
    for (int k = 1; k <= N; k++) if (dv[k]) s += w[k];
    mv = VW'(s % (1 << VW));
    mo = (s >= (1 << VW));
  endfunction

  // Present dv, accept it, return once out_valid is seen (or the bound expires).
  // lat counts edges from the accepting edge inclusive to DONE entry.
  task automatic run(input logic [N:1] dv, output int lat);
    int w;
    w = 0;
    while (!b1.in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    in_valid = 1'b1;
    d = dv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!b1.out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!b1.out_valid) check("timeout_out_valid", 0, 1);
  endtask

  initial begin
    int lat, l1, l2, l4;
    logic [VW-1:0] mv, v2, v4;
    logic mo;
    logic [N:1] rd;

    tbl[0] = '{17'h00000, 12'd0,    1'b0};
    tbl[1] = '{17'h00001, 12'd1,    1'b0};
    tbl[2] = '{17'h00002, 12'd1974, 1'b0};
    tbl[3] = '{17'h10000, 12'd2,    1'b0};
    tbl[4] = '{17'h00007, 12'd3195, 1'b0};
    tbl[5] = '{17'h1FFFF, 12'd1071, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    d = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", b1.in_ready, 0);
    check("rst_out_valid", b1.out_valid, 0);
    check("rst_v", b1.v, 0);
    check("rst_ovf", b1.ovf, 0);
    check("rst_busy", b1.busy, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", b1.in_ready, 1);

    for (int i = 0; i < 6; i++) begin
      run(tbl[i].d, lat);
      check($sformatf("tbl%0d_lat", i), lat, 17);
      check($sformatf("tbl%0d_v", i), b1.v, tbl[i].v);
      check($sformatf("tbl%0d_ovf", i), b1.ovf, tbl[i].ovf);
      @(posedge clk); #1;
      check($sformatf("tbl%0d_pop", i), b1.out_valid, 0);
    end

    // BPC variants decode the same codeword in parallel.
    l1 = 0; l2 = 0; l4 = 0; v2 = '0; v4 = '0;
    in_valid = 1'b1;
    d = 17'h00007;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (b1.out_valid && l1 == 0) l1 = k;
      if (b2.out_valid && l2 == 0) begin l2 = k; v2 = b2.v; end
      if (b4.out_valid && l4 == 0) begin l4 = k; v4 = b4.v; end
      @(posedge clk); #1;
    end
    check("bpc1_lat", l1, 17);
    check("bpc2_lat", l2, 9);
    check("bpc4_lat", l4, 5);
    check("bpc2_v", v2, 3195);
    check("bpc4_v", v4, 3195);

    // Back-pressure: DONE holds, a pending codeword waits for the pop.
    out_ready = 1'b0;
    run(17'h00002, lat);
    in_valid = 1'b1;
    d = 17'h00001;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("bp_v", b1.v, 1974);
      check("bp_out_valid", b1.out_valid, 1);
      check("bp_in_ready", b1.in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_popped", b1.out_valid, 0);
    check("bp_ready_again", b1.in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_busy", b1.busy, 1);
    lat = 0;
    while (!b1.out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check("bp_second_v", b1.v, 1);
    @(posedge clk); #1;

    // Reset during RUN discards the codeword.
    in_valid = 1'b1;
    d = 17'h1FFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", b1.out_valid, 0);
    check("midrst_v", b1.v, 0);
    check("midrst_ovf", b1.ovf, 0);
    check("midrst_busy", b1.busy, 0);
    check("midrst_in_ready", b1.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("after_rst_out_valid", b1.out_valid, 0);
    check("after_rst_in_ready", b1.in_ready, 1);
    run(17'h00002, lat);
    check("after_rst_lat", lat, 17);
    check("after_rst_v", b1.v, 1974);
    check("after_rst_ovf", b1.ovf, 0);
    @(posedge clk); #1;

    // Random codewords with random sink stalls against the model.
    for (int i = 0; i < 40; i++) begin
      rd = N'($urandom);
      model(rd, mv, mo);
      out_ready = 1'b0;
      run(rd, lat);
      check("rnd_lat", lat, 17);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      check("rnd_v", b1.v, mv);
      check("rnd_ovf", b1.ovf, mo);
      out_ready = 1'b1;
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
